// File: rtl/spi_storage_responder.sv
// spi_storage_responder
// ---------------------------------------------------------------------------
// Stand-in for an external SPI flash on the MMU storage link. The MMU is the
// SPI controller (mode 0, MSB first). This block answers the flash-like
// subset READ (0x03), PAGE PROGRAM (0x02), READ STATUS (0x05) and
// WRITE ENABLE (0x06) from an internal 2^ADDR_W byte array.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   spi_cs_n          chip select from the controller, active low
//   spi_sck           SPI clock from the controller (f_sck <= f_clk/4)
//   spi_mosi          controller-to-responder data
//   spi_miso          responder-to-controller data (registered)
//   load_we/addr/data backdoor preload port, wins over an SPI write
//   busy              synchronized chip select is asserted
//   wel               write-enable latch
//
// Handshake: there is no valid/ready pair here. A transaction is the span of
// synchronized cs_n low; mosi is sampled on the synchronized sck rise event,
// miso changes on the synchronized sck fall event, and a byte is complete on
// the 8th rise. The FSM state is held in 'state' (enum state_t) so checkers
// can bind to it.
//
// SYNC_STAGES must be 2 or more. ADDR_W must be between 1 and 24.
// ---------------------------------------------------------------------------
module spi_storage_responder #(
  parameter int ADDR_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs_n,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              busy,
  output logic              wel
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CMD       = 3'd1,
    ADDR      = 3'd2,
    READ_DATA = 3'd3,
    PROG_DATA = 3'd4,
    STATUS    = 3'd5,
    IGNORE    = 3'd6
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_PROG  = 8'h02;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_WREN  = 8'h06;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------
  // Synchronizers and edge detection
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   cs_prev;
  logic                   sck_prev;

  // cs_n synchronizer resets to the deasserted level so reset never looks
  // like the start of a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync   <= '1;
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_prev   <= 1'b1;
      sck_prev  <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_prev   <= cs_sync[SYNC_STAGES-1];
      sck_prev  <= sck_sync[SYNC_STAGES-1];
    end
  end

  logic cs_s, sck_s, mosi_s;
  logic cs_fall, cs_rise, sck_rise, sck_fall;

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign cs_fall  = cs_prev & ~cs_s;
  assign cs_rise  = ~cs_prev & cs_s;
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;

  assign busy = ~cs_s;

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  state_t            state;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_in;
  logic [7:0]        shift_out;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        addr_cnt;
  logic              prog_flavour;
  logic              miso_q;

  logic [7:0]        mem [0:(1<<ADDR_W)-1];

  logic [7:0]        in_byte;
  logic [7:0]        status_byte;
  logic [ADDR_W-1:0] addr_sh;
  logic              byte_done;
  logic              spi_wr;

  always_comb begin
    in_byte     = {shift_in[6:0], mosi_s};
    status_byte = {6'b0, wel, 1'b0};
    // Shifting a new address byte in: upper bits beyond ADDR_W fall off.
    addr_sh     = ADDR_W'({addr, in_byte});
    byte_done   = sck_rise & ~cs_s & (bit_cnt == 3'd7) & (state != IDLE);
    spi_wr      = byte_done & (state == PROG_DATA);
  end

  assign spi_miso = miso_q;

  // Array: not reset. Backdoor load has priority; a colliding SPI byte is lost.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem[load_addr] <= load_data;
    end else if (spi_wr) begin
      mem[addr] <= in_byte;
    end
  end

  // ---------------------------------------------------------------------
  // Transaction FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      shift_in     <= 8'h00;
      shift_out    <= 8'h00;
      addr         <= '0;
      addr_cnt     <= 2'd0;
      prog_flavour <= 1'b0;
      miso_q       <= 1'b0;
      wel          <= 1'b0;
    end else if (cs_rise) begin
      // End of frame from any state. An aborted or completed program
      // sequence consumes the write enable.
      state   <= IDLE;
      bit_cnt <= 3'd0;
      miso_q  <= 1'b0;
      if ((state == ADDR && prog_flavour) || state == PROG_DATA) begin
        wel <= 1'b0;
      end
    end else if (state == IDLE) begin
      if (cs_fall) begin
        state    <= CMD;
        bit_cnt  <= 3'd0;
        shift_in <= 8'h00;
        addr_cnt <= 2'd0;
      end
    end else if (!cs_s) begin
      if (sck_fall) begin
        if (state == READ_DATA || state == STATUS) begin
          miso_q    <= shift_out[7];
          shift_out <= {shift_out[6:0], 1'b0};
        end else begin
          miso_q <= 1'b0;
        end
      end

      if (sck_rise) begin
        shift_in <= in_byte;
        bit_cnt  <= bit_cnt + 3'd1;
        if (byte_done) begin
          case (state)
            CMD: begin
              case (in_byte)
                CMD_READ: begin
                  state        <= ADDR;
                  prog_flavour <= 1'b0;
                  addr_cnt     <= 2'd0;
                end
                CMD_PROG: begin
                  state        <= wel ? ADDR : IGNORE;
                  prog_flavour <= 1'b1;
                  addr_cnt     <= 2'd0;
                end
                CMD_RDSR: begin
                  state     <= STATUS;
                  shift_out <= status_byte;
                end
                CMD_WREN: begin
                  wel   <= 1'b1;
                  state <= IGNORE;
                end
                default: state <= IGNORE;
              endcase
            end
            ADDR: begin
              addr     <= addr_sh;
              addr_cnt <= addr_cnt + 2'd1;
              if (addr_cnt == 2'd2) begin
                if (prog_flavour) begin
                  state <= PROG_DATA;
                end else begin
                  // First read byte is loaded now so its MSB is ready
                  // for the very next fall.
                  state     <= READ_DATA;
                  shift_out <= mem[addr_sh];
                  addr      <= addr_sh + ADDR_ONE;
                end
              end
            end
            READ_DATA: begin
              shift_out <= mem[addr];
              addr      <= addr + ADDR_ONE;
            end
            PROG_DATA: begin
              addr <= addr + ADDR_ONE;
            end
            STATUS: begin
              shift_out <= status_byte;
            end
            IGNORE: begin
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/spi_storage_responder.md
Name: spi_storage_responder

Overview:
- Synthesizable SPI flash responder: the peripheral end of the MMU's external-storage SPI link.
- The MMU is the SPI controller on that link and drives cs_n/sck/mosi; this block answers those transactions from an internal byte array.
- Used for FPGA bring-up and simulation in place of a physical flash part.
- Implements a flash-like command subset: READ, PAGE PROGRAM, READ STATUS, WRITE ENABLE.

Parameters:
ADDR_W, 12, byte-address width of the internal array; depth is 2^ADDR_W bytes.
SYNC_STAGES, 2, synchronizer flops on cs_n, sck and mosi.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
spi_cs_n  input  1  chip select from MMU, active low
spi_sck  input  1  SPI clock from MMU, mode 0
spi_mosi  input  1  controller-to-responder data, MSB first
spi_miso  output  1  responder-to-controller data
load_we  input  1  backdoor preload write strobe
load_addr  input  ADDR_W  backdoor preload address
load_data  input  8  backdoor preload data
busy  output  1  synchronized cs_n asserted (low)
wel  output  1  write-enable latch state

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - FSM = IDLE; bit_cnt = 0; shift registers = 0.
  - spi_miso = 0, busy = 0, wel = 0.
  - Array contents are NOT cleared by reset.
- Synchronization:
  - cs_n, sck and mosi each pass through SYNC_STAGES flops.
  - Edge detect on synchronized sck: a rise event and a fall event, each one clk cycle wide.
  - Requirement: f_sck <= f_clk/4.
- SPI mode 0:
  - mosi is sampled on the sck rise event.
  - spi_miso is updated on the sck fall event.
  - Bits are MSB first.
  - bit_cnt counts 0..7 and wraps; a byte is complete on the 8th rise.
- Output byte timing:
  - At byte completion, the next output byte is computed.
  - Its MSB drives spi_miso on the following fall event; the remaining bits shift on later falls.
- spi_miso is 0 in every state except READ_DATA and STATUS.
- FSM states: IDLE, CMD, ADDR, READ_DATA, PROG_DATA, STATUS, IGNORE.
- IDLE -> CMD on cs_n falling (synchronized). bit_cnt is cleared on entry.
- CMD: on byte complete, dispatch on the command byte:
  - 0x03 -> ADDR (read flavour).
  - 0x02 -> ADDR (program flavour) if wel = 1, else IGNORE.
  - 0x05 -> STATUS.
  - 0x06 -> set wel, then IGNORE.
  - Any other value -> IGNORE.
- ADDR:
  - Collects 3 bytes as a 24-bit address; only the low ADDR_W bits are kept.
  - After the 3rd byte: read flavour -> READ_DATA, program flavour -> PROG_DATA.
- READ_DATA:
  - The output byte is mem[addr]; addr increments after each byte is loaded.
  - Increment wraps modulo 2^ADDR_W.
  - Unbounded length, until cs_n deasserts.
- PROG_DATA:
  - Each completed input byte writes mem[addr]; addr increments with wrap.
  - A partial byte at cs_n deassert is discarded.
- STATUS:
  - Returns status byte {6'b0, wel, 1'b0}; bit 0 is WIP, always 0.
  - The byte repeats while cs_n remains low.
- IGNORE: no writes, miso = 0, waits for cs_n deassert.
- cs_n rising (synchronized), from any state:
  - FSM -> IDLE, bit_cnt = 0, spi_miso = 0.
  - If the FSM was in ADDR (program flavour) or PROG_DATA, wel is cleared.
  - wel set by 0x06 persists across cs_n deassert.
- sck edges while cs_n is high are ignored.
- busy equals the inverted synchronized cs_n.
- Backdoor preload:
  - load_we writes mem[load_addr] = load_data in the same cycle.
  - If an SPI write and a load hit the same cycle, the load wins and the SPI byte for that cycle is dropped.
- Reset mid-transaction: immediate return to IDLE; the array keeps bytes already written.

Test Plan:
- Preload mem[0x010..0x013] = 0xDE,0xAD,0xBE,0xEF; send 0x03,0x00,0x00,0x10 then clock 32 bits -> miso returns 0xDEADBEEF.
- Send 0x02 with wel = 0, addr 0x000020, data 0x55 -> mem[0x020] unchanged, wel stays 0.
- Write sequence:
  - Send 0x06 in its own cs_n frame, then 0x05 -> status 0x02.
  - Send 0x02, addr 0x000020, data 0x11,0x22 -> mem[0x020] = 0x11, mem[0x021] = 0x22.
  - Send 0x05 again -> status 0x00 (wel cleared).
- Wrap: preload mem[0xFFF] = 0xA5, mem[0x000] = 0x5A; send READ at addr 0x000FFF and clock 2 bytes -> 0xA5, 0x5A.
- Send 0x9F (unknown) then 16 sck cycles -> miso stays 0, no array change, next READ frame works normally.
- Assert rst during PROG_DATA after 4 of 8 data bits -> spi_miso = 0, busy = 0, wel = 0, target byte unchanged; previously written bytes retained.
